// File: rtl/hazard_ctrl.sv
// Hazard control: EX-stage forwarding select, load-use stall and multi-cycle mult/div stall.
// Optional stall statistics counter is enabled by defining HAZARD_STATS_EN.
module hazard_ctrl #(
    parameter int unsigned MD_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] IF_ID_rs,
    input  logic [4:0] IF_ID_rt,
    input  logic [4:0] ID_EX_rs,
    input  logic [4:0] ID_EX_rt,
    input  logic       ID_EX_MemRead,
    input  logic [4:0] EX_MEM_rd,
    input  logic [4:0] MEM_WB_rd,
    input  logic       EX_MEM_RegWrite,
    input  logic       MEM_WB_RegWrite,
    input  logic       md_start,
    output logic [1:0] Forward1A,
    output logic [1:0] Forward1B,
    output logic       PC_Write,
    output logic       IF_ID_Write,
    output logic       ID_EX_Flush,
    output logic       md_busy,
    output logic       md_done
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StLoadStall, StMdBusy} state_e;

    localparam logic [5:0] MdLoad = 6'(MD_CYCLES - 1);

    state_e     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       load_use;

    // The newest producer (EX/MEM) wins over MEM/WB; $zero is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (EX_MEM_RegWrite && (EX_MEM_rd != 5'd0) && (EX_MEM_rd == src)) begin
            return 2'b10;
        end else if (MEM_WB_RegWrite && (MEM_WB_rd != 5'd0) && (MEM_WB_rd == src)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_comb begin
        Forward1A = fwd_sel(ID_EX_rs);
        Forward1B = fwd_sel(ID_EX_rt);
    end

    assign load_use = ID_EX_MemRead && (ID_EX_rt != 5'd0) &&
                      ((ID_EX_rt == IF_ID_rs) || (ID_EX_rt == IF_ID_rt));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        ID_EX_Flush = 1'b0;
        md_busy     = 1'b0;
        md_done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                // md_start takes priority; a pending load-use is re-checked on return.
                if (md_start) begin
                    state_d = StMdBusy;
                    cnt_d   = MdLoad;
                end else if (load_use) begin
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_EX_Flush = 1'b1;
                    state_d     = StLoadStall;
                end
            end
            StLoadStall: begin
                state_d = StIdle;
            end
            StMdBusy: begin
                md_busy     = 1'b1;
                PC_Write    = 1'b0;
                IF_ID_Write = 1'b0;
                if (cnt_q == 6'd0) begin
                    md_done = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Outputs take their reset values immediately while reset is held.
        if (!rst_n) begin
            PC_Write    = 1'b1;
            IF_ID_Write = 1'b1;
            ID_EX_Flush = 1'b0;
            md_busy     = 1'b0;
            md_done     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
        end else if (!PC_Write && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a cycle-level behavioural model checked every cycle.
module tb_hazard_ctrl;

    localparam int MDC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] IF_ID_rs, IF_ID_rt, ID_EX_rs, ID_EX_rt, EX_MEM_rd, MEM_WB_rd;
    logic       ID_EX_MemRead, EX_MEM_RegWrite, MEM_WB_RegWrite, md_start;
    logic [1:0] Forward1A, Forward1B;
    logic       PC_Write, IF_ID_Write, ID_EX_Flush, md_busy, md_done;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Model state: remaining busy cycles, and whether the last cycle was a load-use stall.
    int md_left = 0;
    bit ls_cool = 1'b0;
    int unsigned stalls = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_CYCLES(MDC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .IF_ID_rs        (IF_ID_rs),
        .IF_ID_rt        (IF_ID_rt),
        .ID_EX_rs        (ID_EX_rs),
        .ID_EX_rt        (ID_EX_rt),
        .ID_EX_MemRead   (ID_EX_MemRead),
        .EX_MEM_rd       (EX_MEM_rd),
        .MEM_WB_rd       (MEM_WB_rd),
        .EX_MEM_RegWrite (EX_MEM_RegWrite),
        .MEM_WB_RegWrite (MEM_WB_RegWrite),
        .md_start        (md_start),
        .Forward1A       (Forward1A),
        .Forward1B       (Forward1B),
        .PC_Write        (PC_Write),
        .IF_ID_Write     (IF_ID_Write),
        .ID_EX_Flush     (ID_EX_Flush),
        .md_busy         (md_busy),
        .md_done         (md_done)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        if (EX_MEM_RegWrite && EX_MEM_rd != 0 && EX_MEM_rd == src) return 2'b10;
        if (MEM_WB_RegWrite && MEM_WB_rd != 0 && MEM_WB_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_lu();
        return ID_EX_MemRead && ID_EX_rt != 0 && (ID_EX_rt == IF_ID_rs || ID_EX_rt == IF_ID_rt);
    endfunction

    function automatic bit m_lu_stall();
        return rst_n && md_left == 0 && !ls_cool && !md_start && m_lu();
    endfunction

    function automatic bit m_pc();
        return !((rst_n && md_left > 0) || m_lu_stall());
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            md_left = 0;
            ls_cool = 1'b0;
            stalls  = 0;
        end else begin
            if (!m_pc() && stalls != 32'hFFFF_FFFF) stalls++;
            if (md_left > 0) md_left--;
            else if (ls_cool) ls_cool = 1'b0;
            else if (md_start) md_left = MDC;
            else if (m_lu()) ls_cool = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            md_left = 0;
            ls_cool = 1'b0;
            stalls  = 0;
        end
        check("m_fwdA", 32'(Forward1A), 32'(exp_fwd(ID_EX_rs)));
        check("m_fwdB", 32'(Forward1B), 32'(exp_fwd(ID_EX_rt)));
        check("m_pc_write", 32'(PC_Write), 32'(m_pc()));
        check("m_if_id_write", 32'(IF_ID_Write), 32'(m_pc()));
        check("m_flush", 32'(ID_EX_Flush), 32'(m_lu_stall()));
        check("m_busy", 32'(md_busy), 32'(rst_n && md_left > 0));
        check("m_done", 32'(md_done), 32'(rst_n && md_left == 1));
`ifdef HAZARD_STATS_EN
        check("m_stall_cnt", stall_cnt, stalls);
`endif
    end

    task automatic clr();
        {IF_ID_rs, IF_ID_rt, ID_EX_rs, ID_EX_rt, EX_MEM_rd, MEM_WB_rd} = '0;
        {ID_EX_MemRead, EX_MEM_RegWrite, MEM_WB_RegWrite, md_start} = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu();
        ID_EX_MemRead = 1'b1;
        ID_EX_rt      = 5'd8;
        IF_ID_rt      = 5'd8;
    endtask

    initial begin
        int done_seen;
        clr();
        rst_n = 1'b0;
        // Hazards and md_start under reset must not disturb the stall outputs.
        set_lu();
        md_start        = 1'b1;
        EX_MEM_RegWrite = 1'b1;
        EX_MEM_rd       = 5'd8;
        @(negedge clk);
        check("rst_pc_write", 32'(PC_Write), 32'd1);
        check("rst_flush", 32'(ID_EX_Flush), 32'd0);
        check("rst_busy", 32'(md_busy), 32'd0);
        check("rst_fwdB_comb", 32'(Forward1B), 32'd2);
        tick();
        clr();
        rst_n = 1'b1;

        // Double forwarding: EX/MEM wins.
        {EX_MEM_rd, MEM_WB_rd, ID_EX_rs} = {5'd5, 5'd5, 5'd5};
        {EX_MEM_RegWrite, MEM_WB_RegWrite} = 2'b11;
        @(negedge clk);
        check("double_fwd", 32'(Forward1A), 32'd2);
        tick();
        clr();
        // $zero guard on A, MEM/WB forward on B.
        EX_MEM_RegWrite = 1'b1;
        MEM_WB_RegWrite = 1'b1;
        MEM_WB_rd       = 5'd7;
        ID_EX_rt        = 5'd7;
        @(negedge clk);
        check("zero_guard", 32'(Forward1A), 32'd0);
        check("memwb_fwdB", 32'(Forward1B), 32'd1);
        tick();
        clr();
        {EX_MEM_rd, MEM_WB_rd, ID_EX_rs} = {5'd9, 5'd9, 5'd9};
        MEM_WB_RegWrite = 1'b1;
        @(negedge clk);
        check("exmem_we_off", 32'(Forward1A), 32'd1);
        tick();
        clr();

        // Load whose rt is $zero never stalls.
        ID_EX_MemRead = 1'b1;
        @(negedge clk);
        check("lu_zero", 32'(PC_Write), 32'd1);
        tick();

        // Load-use: one stall cycle, then advance even though inputs persist.
        set_lu();
        @(negedge clk);
        check("lu_pc", 32'(PC_Write), 32'd0);
        check("lu_flush", 32'(ID_EX_Flush), 32'd1);
        tick();
        check("lu_next_pc", 32'(PC_Write), 32'd1);
        check("lu_next_flush", 32'(ID_EX_Flush), 32'd0);
        clr();
        tick();

        // Mult/div timing; a second md_start mid-run is ignored.
        md_start = 1'b1;
        @(negedge clk);
        check("md_issue_busy", 32'(md_busy), 32'd0);
        tick();
        md_start = 1'b0;
        for (int i = 0; i < MDC; i++) begin
            md_start = (i == 1);
            @(negedge clk);
            check("md_busy", 32'(md_busy), 32'd1);
            check("md_done", 32'(md_done), 32'(i == MDC - 1));
            tick();
        end
        md_start = 1'b0;
        @(negedge clk);
        check("md_after_pc", 32'(PC_Write), 32'd1);
        check("md_after_busy", 32'(md_busy), 32'd0);
        tick();

        // md_start with load-use: busy first, stall after done if hazard persists.
        set_lu();
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        for (int i = 0; i < MDC; i++) begin
            @(negedge clk);
            check("sim_busy", 32'(md_busy), 32'd1);
            tick();
        end
        @(negedge clk);
        check("sim_stall_pc", 32'(PC_Write), 32'd0);
        check("sim_stall_flush", 32'(ID_EX_Flush), 32'd1);
        tick();
        clr();

        // Reset in the second busy cycle aborts without md_done.
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(md_busy), 32'd0);
        check("rst_mid_pc", 32'(PC_Write), 32'd1);
        check("rst_mid_done", 32'(md_done), 32'd0);
`ifdef HAZARD_STATS_EN
        check("rst_mid_stall_cnt", stall_cnt, 32'd0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < MDC + 2; i++) begin
            @(negedge clk);
            if (md_done) done_seen++;
            tick();
        end
        check("rst_no_done", 32'(done_seen), 32'd0);

        // First cycles after reset behave as IDLE.
        set_lu();
        @(negedge clk);
        check("post_rst_lu", 32'(ID_EX_Flush), 32'd1);
        tick();
        clr();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
